// File: rtl/d74ls138_sch_if.sv
// d74ls138_sch_if: select/enable inputs and active-low decoded outputs of the 3-to-8 decoder.
interface d74ls138_sch_if;
    logic       A;
    logic       B;
    logic       C;
    logic       G;
    logic       G2A;
    logic       G2B;
    logic [7:0] Y;
    modport master (output A, B, C, G, G2A, G2B, input Y);
    modport slave (input A, B, C, G, G2A, G2B, output Y);
endinterface

// File: rtl/d74ls138_sch.sv
// d74ls138_sch: registered 74LS138-style 3-to-8 decoder with active-low outputs.
module d74ls138_sch (
    input  logic             clk,
    input  logic             rst,
    d74ls138_sch_if.slave    bus
);
    logic       en;
    logic [2:0] sel;
    logic [7:0] y_d;
    logic [7:0] y_q;
    always_comb begin
        en  = bus.G & ~bus.G2A & ~bus.G2B;
        sel = {bus.C, bus.B, bus.A};
        y_d = en ? ~(8'd1 << sel) : 8'hFF;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= 8'hFF;
        else     y_q <= y_d;
    end
    assign bus.Y = y_q;
endmodule

// File: tb/tb_d74ls138_sch.sv
// tb_d74ls138_sch: directed and randomized checks of the registered decoder against a truth-table model.
module tb_d74ls138_sch;
    logic clk = 1'b0;
    logic rst;
    int checks = 0;
    int errors = 0;
    d74ls138_sch_if bus ();
    d74ls138_sch dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // Active-low one-cold output: all ones minus the weight of the selected line.
    function automatic logic [7:0] ref_y(input logic [2:0] s, input logic g, input logic g2a, input logic g2b);
        int p;
        p = 1;
        for (int i = 0; i < int'(s); i++) p = p * 2;
        return (g && !g2a && !g2b) ? 8'(255 - p) : 8'hFF;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic g, input logic g2a, input logic g2b);
        @(negedge clk);
        {bus.C, bus.B, bus.A} = s;
        bus.G = g;
        bus.G2A = g2a;
        bus.G2B = g2b;
    endtask

    task automatic step(input string tag, input logic [7:0] exp);
        @(posedge clk);
        #1;
        chk(tag, bus.Y, exp);
        chk({tag, "_model"}, bus.Y, ref_y({bus.C, bus.B, bus.A}, bus.G, bus.G2A, bus.G2B));
    endtask

    task automatic pulse_rst(input string tag);
        #1 rst = 1'b1;
        #1 chk(tag, bus.Y, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] sweep [8];
        logic [2:0] s;
        logic g, a2, b2;
        sweep = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        rst = 1'b1;
        {bus.C, bus.B, bus.A} = 3'd0;
        bus.G = 1'b1;
        bus.G2A = 1'b0;
        bus.G2B = 1'b0;
        #2 chk("rst_async", bus.Y, 8'hFF);
        repeat (2) @(posedge clk);
        #1 chk("rst_hold", bus.Y, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        step("rst_release", 8'hFE);
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 1'b1, 1'b0, 1'b0);
            step($sformatf("sweep%0d", i), sweep[i]);
        end
        for (int i = 0; i < 8; i++) begin
            drive(3'(i), 1'b0, 1'b0, 1'b0);
            step($sformatf("g_low%0d", i), 8'hFF);
        end
        drive(3'd5, 1'b1, 1'b1, 1'b0);
        step("g2a_high", 8'hFF);
        drive(3'd5, 1'b1, 1'b0, 1'b1);
        step("g2b_high", 8'hFF);
        drive(3'd5, 1'b1, 1'b0, 1'b0);
        step("reenable", 8'hDF);
        drive(3'd3, 1'b1, 1'b0, 1'b0);
        step("sel3", 8'hF7);
        pulse_rst("mid_rst");
        step("mid_rst_release", 8'hF7);
        for (int n = 0; n < 300; n++) begin
            s = 3'($urandom_range(0, 7));
            g = 1'($urandom_range(0, 3) != 0);
            a2 = 1'($urandom_range(0, 3) == 0);
            b2 = 1'($urandom_range(0, 3) == 0);
            drive(s, g, a2, b2);
            @(posedge clk);
            #1 chk($sformatf("rand%0d", n), bus.Y, ref_y(s, g, a2, b2));
            if ($urandom_range(0, 15) == 0) pulse_rst($sformatf("rand_rst%0d", n));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/d74ls138_sch.md
D74LS138_SCH -- requirements
Module: d74ls138_sch

Interface
Parameters: none.
REQ-001 SHALL have ports clk and rst as listed below.
- One clock: clk.
- Reset: rst, asynchronous, active-high.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: A  input  1  select bit 0 (LSB).
REQ-005 SHALL have port: B  input  1  select bit 1.
REQ-006 SHALL have port: C  input  1  select bit 2 (MSB).
REQ-007 SHALL have port: G  input  1  enable, active-high (74LS138 G1).
REQ-008 SHALL have port: G2A  input  1  enable, active-low.
REQ-009 SHALL have port: G2B  input  1  enable, active-low.
REQ-010 SHALL have port: Y  output  8  decoded outputs, active-low, registered.

Function
REQ-011 SHALL define enable as en = G & ~G2A & ~G2B.
REQ-012 SHALL define the select index as sel = {C,B,A}, where C is the MSB, giving values 0..7.
REQ-013 SHALL compute the next value of Y as follows:
- en=1: Y[i]=0 for i=sel; all other bits 1 (exactly one bit low).
- en=0: Y=8'hFF regardless of sel.
REQ-014 SHALL register Y on every rising clk edge when rst=0, giving a latency of exactly 1 cycle from an input change to Y.
REQ-015 SHALL have no other state, handshake or enable-hold; Y depends only on the inputs sampled at the last edge.
REQ-016 SHALL make the enable gating take priority over sel: any single disabling condition forces 8'hFF.
- Disabling conditions: G=0, G2A=1 or G2B=1.
- Combinations of disabling conditions also force 8'hFF.
REQ-017 SHALL update Y at each edge to the decode of the current inputs when sel changes on consecutive cycles, with no glitch or hold-over between values.
REQ-018 SHALL drive Y with no X/Z once reset has been applied; Y SHALL never show more than one low bit.

Reset
REQ-019 SHALL force Y=8'hFF immediately when rst is asserted, without waiting for a clk edge.
REQ-020 SHALL hold Y=8'hFF for as long as rst=1, overriding all inputs.
REQ-021 SHALL resume decoding at the first rising clk edge after rst is deasserted, using the inputs sampled at that edge.
REQ-022 SHALL return Y to 8'hFF asynchronously when rst is asserted mid-operation, discarding any pending decode.

Verification
REQ-023 SHALL be covered by a bench scenario: rst pulse with G=1, G2A=0, G2B=0, sel=0 -> Y=8'hFF during reset; Y=8'hFE one edge after release.
REQ-024 SHALL be covered by a bench scenario: enabled (G=1, G2A=0, G2B=0), sweep sel 0..7, one value per cycle -> Y sequence after 1 cycle latency:
- FE, FD, FB, F7, EF, DF, BF, 7F.
REQ-025 SHALL be covered by a bench scenario: G=0, G2A=0, G2B=0, every sel -> Y=8'hFF.
REQ-026 SHALL be covered by a bench scenario: G=1, G2A=1, G2B=0, sel=5 -> Y=8'hFF; then G2A=0, G2B=1 -> Y=8'hFF; then G2B=0 -> Y=8'hDF next edge.
REQ-027 SHALL be covered by a bench scenario: enabled, sel=3 giving Y=8'hF7; assert rst between clk edges -> Y=8'hFF before the next edge.
- Deassert rst -> Y=8'hF7 at the following edge.
